// File: rtl/sponge_pkg.sv
// Shared definitions for the sponge absorb/squeeze stages: FSM encoding,
// default widths and the final-block padding rule.
package sponge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PERM,
        PWAIT,
        PADBLK,
        DONE
    } absorb_state_t;

    localparam int SPONGE_SWIDTH = 320;
    localparam int SPONGE_RWIDTH = 32;
    localparam int SPONGE_NBW    = $clog2(SPONGE_RWIDTH + 1);

    // 10*-style padding at the default rate width: keep the top nbits of
    // data, set the next bit, clear the rest (nbits >= rate is clamped).
    function automatic logic [SPONGE_RWIDTH-1:0] pad_block(
        input logic [SPONGE_RWIDTH-1:0] data,
        input logic [SPONGE_NBW-1:0]    nbits
    );
        logic [SPONGE_RWIDTH-1:0] blk;
        int n;
        n = int'(nbits);
        if (n > SPONGE_RWIDTH) n = SPONGE_RWIDTH;
        for (int i = 0; i < SPONGE_RWIDTH; i++) begin
            if (SPONGE_RWIDTH - 1 - i < n)       blk[i] = data[i];
            else if (SPONGE_RWIDTH - 1 - i == n) blk[i] = 1'b1;
            else                                 blk[i] = 1'b0;
        end
        return blk;
    endfunction

endpackage

// File: rtl/sponge_pad.sv
// Combinational masking/padding of a message block before it is XORed
// into the rate. Non-final blocks pass through untouched.
module sponge_pad
    import sponge_pkg::*;
#(
    parameter  int RWIDTH = SPONGE_RWIDTH,
    localparam int NBW    = $clog2(RWIDTH + 1)
) (
    input  logic [RWIDTH-1:0] in_data,
    input  logic [NBW-1:0]    in_nbits,
    input  logic              in_last,
    output logic [RWIDTH-1:0] blk,
    output logic              full_last
);

    int n_clamp;

    always_comb begin
        n_clamp = int'(in_nbits);
        if (n_clamp > RWIDTH) n_clamp = RWIDTH;
        blk       = in_data;
        full_last = 1'b0;
        if (in_last) begin
            for (int i = 0; i < RWIDTH; i++) begin
                if (RWIDTH - 1 - i < n_clamp)       blk[i] = in_data[i];
                else if (RWIDTH - 1 - i == n_clamp) blk[i] = 1'b1;
                else                                blk[i] = 1'b0;
            end
            // A completely full final block leaves no room for the pad bit,
            // so a separate padding-only block must follow.
            full_last = (n_clamp == RWIDTH);
        end
    end

endmodule

// File: rtl/sponge_absorb.sv
// Sponge absorb phase: XORs padded message blocks into the rate, runs the
// external permutation after each block, then hands the state to squeeze.
module sponge_absorb
    import sponge_pkg::*;
#(
    parameter  int SWIDTH = SPONGE_SWIDTH,
    parameter  int RWIDTH = SPONGE_RWIDTH,
    localparam int NBW    = $clog2(RWIDTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RWIDTH-1:0] in_data,
    input  logic              in_last,
    input  logic [NBW-1:0]    in_nbits,
    output logic              perm_start,
    output logic [SWIDTH-1:0] perm_state_out,
    input  logic [SWIDTH-1:0] perm_state_in,
    input  logic              perm_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SWIDTH-1:0] out_state
);

    absorb_state_t     fsm_q, fsm_d;
    logic [SWIDTH-1:0] state_q, state_d;
    logic              last_flag_q, last_flag_d;
    logic              pad_pending_q, pad_pending_d;
    logic [RWIDTH-1:0] blk;
    logic              full_last;

    sponge_pad #(.RWIDTH(RWIDTH)) u_pad (
        .in_data   (in_data),
        .in_nbits  (in_nbits),
        .in_last   (in_last),
        .blk       (blk),
        .full_last (full_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q         <= IDLE;
            state_q       <= '0;
            last_flag_q   <= 1'b0;
            pad_pending_q <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            state_q       <= state_d;
            last_flag_q   <= last_flag_d;
            pad_pending_q <= pad_pending_d;
        end
    end

    always_comb begin
        fsm_d         = fsm_q;
        state_d       = state_q;
        last_flag_d   = last_flag_q;
        pad_pending_d = pad_pending_q;
        perm_start    = 1'b0;
        out_valid     = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d[SWIDTH-1 -: RWIDTH] = state_q[SWIDTH-1 -: RWIDTH] ^ blk;
                    last_flag_d   = in_last;
                    pad_pending_d = full_last;
                    fsm_d         = PERM;
                end
            end
            PERM: begin
                perm_start = 1'b1;
                fsm_d      = PWAIT;
            end
            PWAIT: begin
                if (perm_done) begin
                    state_d = perm_state_in;
                    if (pad_pending_q)    fsm_d = PADBLK;
                    else if (last_flag_q) fsm_d = DONE;
                    else                  fsm_d = IDLE;
                end
            end
            PADBLK: begin
                state_d[SWIDTH-1] = ~state_q[SWIDTH-1];
                pad_pending_d     = 1'b0;
                fsm_d             = PERM;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d     = '0;
                    last_flag_d = 1'b0;
                    fsm_d       = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // FSM sits in IDLE while reset is held, so ready is gated explicitly.
    assign in_ready       = (fsm_q == IDLE) && !reset;
    assign perm_state_out = state_q;
    assign out_state      = state_q;

endmodule
